// File: rtl/bitty_fetch.sv
// Instruction fetch stage for the bitty core: owns the PC, issues one memory
// request at a time and buffers fetched words with their PC in a small FIFO.
module bitty_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    input  logic [INSTR_W-1:0]            mem_rdata,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [INSTR_W-1:0]            instr_out,
    output logic [ADDR_W-1:0]             instr_pc,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic [$clog2(DEPTH):0]        fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [ADDR_W-1:0]   target, target_nxt;
    logic [CW-1:0]       count, count_post;
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic                push, pop;

    logic [INSTR_W-1:0]  word_q [DEPTH];
    logic [ADDR_W-1:0]   pc_q   [DEPTH];

    assign mem_req     = (state != S_IDLE);
    assign mem_addr    = pc;
    assign fifo_count  = count;
    assign instr_valid = (count != '0);
    assign instr_out   = instr_valid ? word_q[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr]   : '0;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        target_nxt = target;
        push       = 1'b0;
        pop        = instr_valid && instr_ready && !redirect_valid;
        count_post = pop ? count : count + CW'(1);
        unique case (state)
            S_IDLE: begin
                if (redirect_valid)
                    pc_nxt = redirect_pc;
                else if (en && (count < DEPTH_C))
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    // An unacked request cannot be withdrawn, so park the target
                    if (mem_ack) begin
                        pc_nxt    = redirect_pc;
                        state_nxt = S_IDLE;
                    end else begin
                        target_nxt = redirect_pc;
                        state_nxt  = S_DISCARD;
                    end
                end else if (mem_ack) begin
                    push      = 1'b1;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = (en && (count_post < DEPTH_C)) ? S_REQ : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (mem_ack) begin
                    pc_nxt    = redirect_valid ? redirect_pc : target;
                    state_nxt = S_IDLE;
                end else if (redirect_valid) begin
                    target_nxt = redirect_pc;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            target <= '0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            target <= target_nxt;
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (pop && !push)
                    count <= count - CW'(1);
            end
        end
    end

    // Storage carries no reset; the count gates what is visible downstream
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]   <= pc;
        end
    end

endmodule

// File: tb/tb_bitty_fetch.sv
// Randomized bench for bitty_fetch against a queue-based transaction model.
module tb_bitty_fetch;

    localparam int         DEPTH    = 2;
    localparam logic [7:0] RESET_PC = 8'hFE;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [1:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;

    bitty_fetch #(
        .ADDR_W  (8),
        .INSTR_W (16),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  pc;
    } ent_t;

    ent_t       q[$];
    logic [7:0] m_pc;
    logic [7:0] m_target;
    bit         m_busy;   // a real request is outstanding
    bit         m_drop;   // outstanding request's data will be thrown away

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc     = RESET_PC;
        m_target = 8'h00;
        m_busy   = 1'b0;
        m_drop   = 1'b0;
    endtask

    task automatic compare_all();
        chk("mem_req",     32'(mem_req),     32'(m_busy || m_drop));
        chk("mem_addr",    32'(mem_addr),    32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
        chk("instr_out",   32'(instr_out),   (q.size() != 0) ? 32'(q[0].ins) : 32'h0);
        chk("instr_pc",    32'(instr_pc),    (q.size() != 0) ? 32'(q[0].pc)  : 32'h0);
        chk("fifo_count",  32'(fifo_count),  32'(q.size()));
    endtask

    // Advance the model by one clock using the inputs about to be sampled
    task automatic model_step(input bit e, input bit r, input bit a, input bit rv,
                              input logic [7:0] rp, input logic [15:0] rd);
        bit popped;
        if (rv) begin
            q.delete();
            if (m_drop) begin
                if (a) begin m_pc = rp; m_drop = 1'b0; end
                else m_target = rp;
            end else if (m_busy) begin
                m_busy = 1'b0;
                if (a) m_pc = rp;
                else begin m_target = rp; m_drop = 1'b1; end
            end else begin
                m_pc = rp;
            end
        end else begin
            popped = (q.size() != 0) && r;
            if (m_drop) begin
                if (a) begin m_pc = m_target; m_drop = 1'b0; end
            end else if (m_busy) begin
                if (a) begin
                    q.push_back('{ins: rd, pc: m_pc});
                    m_pc   = m_pc + 8'd1;
                    m_busy = e && ((q.size() - int'(popped)) < DEPTH);
                end
            end else begin
                m_busy = e && (q.size() < DEPTH);
            end
            if (popped) void'(q.pop_front());
        end
    endtask

    task automatic cyc(input bit e, input bit r, input bit a, input bit rv, input logic [7:0] rp);
        logic [15:0] rd;
        rd = 16'($urandom);
        en = e; instr_ready = r; mem_ack = a; redirect_valid = rv; redirect_pc = rp;
        mem_rdata = rd;
        model_step(e, r, a, rv, rp, rd);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Zero-wait streaming across the address wrap
        for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 8'h00);

        // Back-pressure fills the FIFO, then drain and resume
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 8'h00);

        // Slow memory: redirect while a request waits for its ack
        cyc(1, 1, 1, 1, 8'h05);
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 1, 8'h40);
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 8'h00);

        // Redirect coincident with ack and pop while one word is buffered
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 1, 1, 1, 8'h80);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 8'h00);

        // en dropped while a request is outstanding
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'h00);

        // Asynchronous reset in the middle of a request with data buffered
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        #2 reset = 1'b0;
        #1;
        chk("rst_mem_req",     32'(mem_req),     32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_fifo_count",  32'(fifo_count),  32'h0);
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 8'h00);

        // Random traffic with varying pressure
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) != 0),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 11) == 0),
                8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
